led_cube_uart_tx: RTL and testbench



---
 rtl/led_cube_uart_tx.sv | 149 ++++++++++++++
 tb/tb_led_cube_uart_tx.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_cube_uart_tx.sv
// UART transmit path from the LED cube controller back to the host.
// Bytes queue in a small FIFO and leave on txd as 8N1 (optionally 8E1) frames.
module led_cube_uart_tx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_EN  = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [7:0]                           tx_data,
    input  logic                                 tx_valid,
    output logic                                 tx_ready,
    output logic                                 txd,
    output logic                                 busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
    output logic [2:0]                           state_dbg
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            txd_d;
    logic            push, pop;
    logic            fifo_empty, baud_tick;

    // Handshake: a byte is taken on every rising edge where tx_valid && tx_ready;
    // tx_ready depends only on reset and FIFO occupancy, never on tx_valid.
    assign tx_ready   = !reset && (count != FIFO_FULL);
    assign push       = tx_valid && tx_ready;
    assign fifo_empty = (count == '0);
    assign baud_tick  = (baud_q == BAUD_LAST);
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign fifo_count = count;
    assign state_dbg  = state_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_tick ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        txd_d   = 1'b1;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    par_d   = ^mem[rd_ptr];
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (baud_tick) state_d = S_STOP;
            end
            S_STOP: begin
                // Chain straight into the next start bit so queued bytes leave gap-free.
                if (baud_tick) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        par_d   = ^mem[rd_ptr];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // txd is registered, so it is derived from where the FSM is heading.
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = par_d;
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            txd     <= 1'b1;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            state_q <= state_d;
            txd     <= txd_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

endmodule

// File: tb/tb_led_cube_uart_tx.sv
// Bench for led_cube_uart_tx: two instances (no parity / even parity) checked
// every cycle against a frame-level line model, plus hand-computed waveforms.
module tb_led_cube_uart_tx;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 250;
    localparam int CPB    = 4;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] tx_valid = 2'b00;
    logic [7:0] tx_data [2] = '{8'h00, 8'h00};
    logic       txd0, txd1, busy0, busy1, rdy0, rdy1;
    logic [2:0] cnt0, cnt1, st0, st1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Line model: expected bytes per instance, plus the frame currently on the wire.
    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];
    bit          act [2] = '{0, 0};
    int          el [2] = '{0, 0};
    logic [10:0] frame [2] = '{11'h7ff, 11'h7ff};

    always #5 clk = ~clk;

    led_cube_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH), .PARITY_EN(0)) u_dut0 (
        .clk(clk), .reset(reset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(rdy0), .txd(txd0), .busy(busy0), .fifo_count(cnt0), .state_dbg(st0)
    );

    led_cube_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH), .PARITY_EN(1)) u_dut1 (
        .clk(clk), .reset(reset), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(rdy1), .txd(txd1), .busy(busy1), .fifo_count(cnt1), .state_dbg(st1)
    );

    function automatic int q_size(input int i);
        return (i == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic get_txd(input int i);
        return (i == 0) ? txd0 : txd1;
    endfunction

    function automatic logic get_busy(input int i);
        return (i == 0) ? busy0 : busy1;
    endfunction

    function automatic logic get_rdy(input int i);
        return (i == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic [2:0] get_cnt(input int i);
        return (i == 0) ? cnt0 : cnt1;
    endfunction

    task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        logic [7:0] b;
        bit room;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                if (i == 0) exp_q0.delete(); else exp_q1.delete();
                act[i] = 0;
                el[i]  = 0;
            end else begin
                room = (q_size(i) != DEPTH);
                if (act[i]) begin
                    el[i] = el[i] + 1;
                    if (el[i] == (10 + i) * CPB) act[i] = 0;
                end
                if (!act[i] && q_size(i) != 0) begin
                    if (i == 0) b = exp_q0.pop_front(); else b = exp_q1.pop_front();
                    frame[i] = {1'b1, (i == 0) ? 1'b1 : ^b, b, 1'b0};
                    act[i] = 1;
                    el[i]  = 0;
                end
                if (tx_valid[i] && room) begin
                    if (i == 0) exp_q0.push_back(tx_data[i]); else exp_q1.push_back(tx_data[i]);
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("p%0d_txd", i), get_txd(i), act[i] ? frame[i][el[i] / CPB] : 1'b1);
            check($sformatf("p%0d_busy", i), get_busy(i), act[i] || (q_size(i) != 0));
            check($sformatf("p%0d_fifo_count", i), get_cnt(i), q_size(i));
            check($sformatf("p%0d_tx_ready", i), get_rdy(i), !reset && (q_size(i) != DEPTH));
        end
    endtask

    // One clock: model on the rising edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (chk_en) compare_all();
    endtask

    task automatic push1(input int i, input logic [7:0] d);
        tx_valid[i] = 1'b1;
        tx_data[i]  = d;
        step();
        tx_valid[i] = 1'b0;
    endtask

    task automatic wait_start(input int i);
        bit ok = 0;
        for (int n = 0; n < 200; n++) begin
            if (get_txd(i) == 1'b0) begin
                ok = 1;
                break;
            end
            step();
        end
        check($sformatf("p%0d_start_seen", i), ok, 1'b1);
    endtask

    task automatic wait_idle(input int i);
        bit ok = 0;
        for (int n = 0; n < 2000; n++) begin
            if (get_busy(i) == 1'b0) begin
                ok = 1;
                break;
            end
            step();
        end
        check($sformatf("p%0d_idle_seen", i), ok, 1'b1);
    endtask

    task automatic frame_capture(input int i, input int n, output logic [127:0] s);
        s = '1;
        wait_start(i);
        s[0] = get_txd(i);
        for (int k = 1; k < n; k++) begin
            step();
            s[k] = get_txd(i);
        end
    endtask

    logic [127:0] s;
    logic [7:0]   d;
    logic [7:0]   t3_exp [3] = '{8'h11, 8'h22, 8'h33};
    int           acc;
    bit           seen;

    initial begin
        // Reset state
        repeat (3) step();
        chk_en = 1;
        check("reset_txd0", txd0, 1'b1);
        check("reset_txd1", txd1, 1'b1);
        check("reset_busy0", busy0, 1'b0);
        check("reset_count0", cnt0, 3'd0);
        check("reset_ready0", rdy0, 1'b0);
        reset = 1'b0;
        step();
        check("ready_after_release", rdy0, 1'b1);

        // Single byte, no parity
        push1(0, 8'hA5);
        frame_capture(0, 40, s);
        check("t1_wave_a5", s[39:0], 40'hFF0F00F0F0);
        check("t1_busy_last_stop", busy0, 1'b1);
        step();
        check("t1_busy_fall", busy0, 1'b0);
        check("t1_txd_idle", txd0, 1'b1);

        // Even parity
        push1(1, 8'h07);
        frame_capture(1, 44, s);
        check("t2_wave_07", s[43:0], 44'hFF00000FFF0);
        wait_idle(1);
        push1(1, 8'h03);
        frame_capture(1, 44, s);
        check("t2_wave_03", s[43:0], 44'hF0000000FF0);
        wait_idle(1);

        // Back-to-back frames
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h11;
        step();
        tx_data[0]  = 8'h22;
        step();
        s = '1;
        s[0] = txd0;
        tx_data[0]  = 8'h33;
        step();
        tx_valid[0] = 1'b0;
        s[1] = txd0;
        for (int k = 2; k < 120; k++) begin
            step();
            s[k] = txd0;
        end
        for (int f = 0; f < 3; f++) begin
            check($sformatf("t3_start_%0d", f), s[40 * f + 2], 1'b0);
            for (int b = 0; b < 8; b++) d[b] = s[40 * f + 4 * (1 + b) + 2];
            check($sformatf("t3_byte_%0d", f), d, t3_exp[f]);
            check($sformatf("t3_stop_%0d", f), s[40 * f + 38], 1'b1);
        end
        step();
        check("t3_busy_after_120", busy0, 1'b0);

        // Overfill with tx_valid held high
        acc = 0;
        for (int n = 0; n < 8; n++) begin
            if (rdy0) begin
                tx_data[0] = 8'(8'h40 + acc);
                acc++;
            end else begin
                tx_data[0] = 8'($urandom_range(0, 255));
            end
            tx_valid[0] = 1'b1;
            step();
        end
        check("t4_accepted", acc, 5);
        check("t4_count_full", cnt0, 3'd4);
        check("t4_ready_low", rdy0, 1'b0);
        seen = 0;
        for (int n = 0; n < 100; n++) begin
            if (rdy0) begin
                seen = 1;
                break;
            end
            tx_data[0] = 8'($urandom_range(0, 255));
            step();
        end
        check("t4_ready_rise_seen", seen, 1'b1);
        check("t4_count_at_rise", cnt0, 3'd3);
        tx_data[0] = 8'(8'h40 + acc);
        step();
        tx_valid[0] = 1'b0;
        check("t4_count_refill", cnt0, 3'd4);
        wait_idle(0);

        // Reset mid-frame with two bytes queued
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h81;
        step();
        tx_data[0]  = 8'h82;
        step();
        tx_data[0]  = 8'h83;
        step();
        tx_valid[0] = 1'b0;
        check("t5_in_frame", txd0, 1'b0);
        repeat (16) step();
        check("t5_queued", cnt0, 3'd2);
        check("t5_bit3", txd0, 1'b0);
        reset = 1'b1;
        step();
        check("t5_reset_txd", txd0, 1'b1);
        check("t5_reset_count", cnt0, 3'd0);
        check("t5_reset_ready", rdy0, 1'b0);
        reset = 1'b0;
        seen = 0;
        for (int n = 0; n < 60; n++) begin
            step();
            if (busy0 || !txd0) seen = 1;
        end
        check("t5_silent_after_reset", seen, 1'b0);
        push1(0, 8'h5A);
        frame_capture(0, 40, s);
        check("t5_wave_5a", s[39:0], 40'hF0F0FF0F00);
        wait_idle(0);

        // Push coinciding with the STOP->START pop
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'hC1;
        step();
        tx_data[0]  = 8'hC2;
        step();
        tx_data[0]  = 8'hC3;
        step();
        tx_valid[0] = 1'b0;
        check("t6_in_frame", txd0, 1'b0);
        repeat (38) step();
        check("t6_count_before", cnt0, 3'd2);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'hC4;
        step();
        tx_valid[0] = 1'b0;
        check("t6_count_after", cnt0, 3'd2);
        check("t6_next_start", txd0, 1'b0);
        wait_idle(0);
        wait_idle(1);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
